// File: rtl/bus_pkg.sv
// Shared types and default sizing for the round-robin bus arbiter.
package bus_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;
  localparam int unsigned DEFAULT_N     = 4;

  typedef enum logic {IDLE, LOCK} arb_state_t;

endpackage

// File: rtl/bus_rr_pick.sv
// Combinational rotating-priority picker: first set request at or above ptr,
// wrapping from N-1 back to 0.
module bus_rr_pick
  import bus_pkg::*;
#(
  parameter  int unsigned N   = DEFAULT_N,
  localparam int unsigned IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic           gnt_valid,
  output logic [IDW-1:0] gnt_id
);

  logic [2*N-1:0] w_req2;
  logic [N-1:0]   w_rot;
  int unsigned    w_sum;

  // Rotate so that bit 0 of w_rot is the requester at ptr.
  assign w_req2 = {req, req};
  assign w_rot  = N'(w_req2 >> ptr);

  // Scan from the highest offset down so the lowest set offset wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = '0;
    w_sum     = 0;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_sum = 32'(ptr) + 32'(k);
        if (w_sum >= N) begin
          w_sum = w_sum - N;
        end
        gnt_valid = 1'b1;
        gnt_id    = IDW'(w_sum);
      end
    end
  end

endmodule

// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter with burst locking onto one valid/ready channel,
// single registered output slot tagged with the source requester index.
module bus_rr_arbiter
  import bus_pkg::*;
#(
  parameter  int unsigned WIDTH = DEFAULT_WIDTH,
  parameter  int unsigned N     = DEFAULT_N,
  localparam int unsigned IDW   = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       valid_dnt,
  input  logic [N*WIDTH-1:0] data_dnt,
  input  logic [N-1:0]       last_dnt,
  output logic [N-1:0]       ready_dnt,
  output logic               valid_src,
  output logic [WIDTH-1:0]   data_src,
  output logic               last_src,
  output logic [IDW-1:0]     id_src,
  input  logic               ready_src
);

  arb_state_t       r_state, w_state_nxt;
  logic [IDW-1:0]   r_lock_id, w_lock_id_nxt;
  logic [IDW-1:0]   r_rr_ptr, w_rr_ptr_nxt;
  logic             r_valid_src;
  logic [WIDTH-1:0] r_data_src;
  logic             r_last_src;
  logic [IDW-1:0]   r_id_src;

  logic             w_gnt_valid;
  logic [IDW-1:0]   w_gnt_id;
  logic [IDW-1:0]   w_sel_id;
  logic             w_slot_free;
  logic             w_grant_en;
  logic             w_xfer;
  logic             w_sel_valid;
  logic             w_sel_last;
  logic [WIDTH-1:0] w_sel_data;

  bus_rr_pick #(.N(N)) u_pick (
    .req       (valid_dnt),
    .ptr       (r_rr_ptr),
    .gnt_valid (w_gnt_valid),
    .gnt_id    (w_gnt_id)
  );

  assign w_slot_free = !r_valid_src || ready_src;
  assign w_sel_id    = (r_state == LOCK) ? r_lock_id : w_gnt_id;
  assign w_grant_en  = ((r_state == LOCK) || w_gnt_valid) && w_slot_free && !rst;
  assign ready_dnt   = w_grant_en ? (N'(1) << w_sel_id) : '0;
  assign w_xfer      = w_grant_en && w_sel_valid;

  // Mux the selected requester's beat using constant slices only.
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_last  = 1'b0;
    w_sel_data  = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (w_sel_id == IDW'(i)) begin
        w_sel_valid = valid_dnt[i];
        w_sel_last  = last_dnt[i];
        w_sel_data  = data_dnt[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_lock_id <= '0;
      r_rr_ptr  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_lock_id <= w_lock_id_nxt;
      r_rr_ptr  <= w_rr_ptr_nxt;
    end
  end

  // A last beat releases the lock and advances the pointer past its source.
  always_comb begin
    w_state_nxt   = r_state;
    w_lock_id_nxt = r_lock_id;
    w_rr_ptr_nxt  = r_rr_ptr;
    if (w_xfer) begin
      if (w_sel_last) begin
        w_state_nxt  = IDLE;
        w_rr_ptr_nxt = (32'(w_sel_id) == N - 1) ? '0 : IDW'(32'(w_sel_id) + 32'd1);
      end else if (r_state == IDLE) begin
        w_state_nxt   = LOCK;
        w_lock_id_nxt = w_sel_id;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid_src <= 1'b0;
      r_data_src  <= '0;
      r_last_src  <= 1'b0;
      r_id_src    <= '0;
    end else if (w_xfer) begin
      r_valid_src <= 1'b1;
      r_data_src  <= w_sel_data;
      r_last_src  <= w_sel_last;
      r_id_src    <= w_sel_id;
    end else if (ready_src) begin
      r_valid_src <= 1'b0;
    end
  end

  assign valid_src = r_valid_src;
  assign data_src  = r_data_src;
  assign last_src  = r_last_src;
  assign id_src    = r_id_src;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Bench for bus_rr_arbiter: directed scenarios on N=4 and N=3 instances plus
// a randomized run against a transaction-level round-robin model.
module tb_bus_rr_arbiter;

  logic         clk;
  logic         rst;

  logic [3:0]   v4, l4, r4;
  logic [127:0] d4;
  logic         vs4, ls4, rs4;
  logic [31:0]  ds4;
  logic [1:0]   id4;

  logic [2:0]   v3, l3, r3;
  logic [95:0]  d3;
  logic         vs3, ls3, rs3;
  logic [31:0]  ds3;
  logic [1:0]   id3;

  int n_checks;
  int n_fail;

  bus_rr_arbiter #(.WIDTH(32), .N(4)) u_dut4 (
    .clk(clk), .rst(rst), .valid_dnt(v4), .data_dnt(d4), .last_dnt(l4),
    .ready_dnt(r4), .valid_src(vs4), .data_src(ds4), .last_src(ls4),
    .id_src(id4), .ready_src(rs4)
  );

  bus_rr_arbiter #(.WIDTH(32), .N(3)) u_dut3 (
    .clk(clk), .rst(rst), .valid_dnt(v3), .data_dnt(d3), .last_dnt(l3),
    .ready_dnt(r3), .valid_src(vs3), .data_src(ds3), .last_src(ls3),
    .id_src(id3), .ready_src(rs3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    v4 = '0; l4 = '0; d4 = '0; rs4 = 1'b0;
    v3 = '0; l3 = '0; d3 = '0; rs3 = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    v4[0] = 1'b1; d4[31:0] = 32'h77; l4[0] = 1'b1; rs4 = 1'b0;
    @(posedge clk); #1 v4 = '0;
    @(negedge clk);
    n_checks++;
    if (vs4 !== 1'b1) begin n_fail++; $display("FAIL reset_preload: valid_src=%b want 1", vs4); end
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if (vs4 !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", vs4); end
    n_checks++;
    if (ds4 !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", ds4); end
    n_checks++;
    if (ls4 !== 1'b0 || id4 !== 2'd0) begin n_fail++; $display("FAIL reset_last_id: got %b/%0d want 0/0", ls4, id4); end
    n_checks++;
    if (r4 !== 4'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0000", r4); end
    @(posedge clk); #2 rst = 1'b0;
    #1;
    n_checks++;
    if (r4 !== 4'b0 || vs4 !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset: ready=%b valid=%b want 0000/0", r4, vs4); end
  endtask

  task automatic test_fairness();
    int exp_id;
    do_reset();
    for (int i = 0; i < 4; i++) d4[i*32 +: 32] = 32'h10 + 32'(i);
    v4 = 4'hF; l4 = 4'hF; rs4 = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      exp_id = k % 4;
      n_checks++;
      if (vs4 !== 1'b1 || id4 !== 2'(exp_id) || ds4 !== 32'h10 + 32'(exp_id)) begin
        n_fail++;
        $display("FAIL fair_beat%0d: valid=%b id=%0d data=%h want 1/%0d/%h", k, vs4, id4, ds4, exp_id, 32'h10 + 32'(exp_id));
      end
      n_checks++;
      if (r4 !== 4'(1 << ((k + 1) % 4))) begin
        n_fail++;
        $display("FAIL fair_ready%0d: got %b want %b", k, r4, 4'(1 << ((k + 1) % 4)));
      end
    end
    v4 = '0;
  endtask

  task automatic test_burst_lock();
    logic [31:0] exp_d [4];
    logic        exp_l [4];
    logic [1:0]  exp_i [4];
    logic [3:0]  exp_r [4];
    exp_d = '{32'hA1, 32'hA2, 32'hA3, 32'hB2};
    exp_l = '{1'b0, 1'b0, 1'b1, 1'b1};
    exp_i = '{2'd1, 2'd1, 2'd1, 2'd2};
    exp_r = '{4'b0010, 4'b0010, 4'b0010, 4'b0100};
    do_reset();
    v4 = 4'b0110; d4[32 +: 32] = 32'hA1; l4 = 4'b0100; d4[64 +: 32] = 32'hB2; rs4 = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c < 4) begin
        n_checks++;
        if (r4 !== exp_r[c]) begin n_fail++; $display("FAIL lock_ready%0d: got %b want %b", c, r4, exp_r[c]); end
      end
      if (c > 0) begin
        n_checks++;
        if (vs4 !== 1'b1 || ds4 !== exp_d[c-1] || ls4 !== exp_l[c-1] || id4 !== exp_i[c-1]) begin
          n_fail++;
          $display("FAIL lock_beat%0d: v=%b d=%h l=%b id=%0d want 1/%h/%b/%0d", c - 1, vs4, ds4, ls4, id4, exp_d[c-1], exp_l[c-1], exp_i[c-1]);
        end
      end
      if (c < 4) begin
        @(posedge clk); #1;
        case (c)
          0: d4[32 +: 32] = 32'hA2;
          1: begin d4[32 +: 32] = 32'hA3; l4[1] = 1'b1; end
          2: v4[1] = 1'b0;
          default: v4[2] = 1'b0;
        endcase
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    v4[0] = 1'b1; d4[31:0] = 32'h5; l4[0] = 1'b1; rs4 = 1'b0;
    @(posedge clk); #1 d4[31:0] = 32'h6;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (vs4 !== 1'b1 || ds4 !== 32'h5 || r4 !== 4'b0) begin
        n_fail++;
        $display("FAIL bp_hold%0d: v=%b d=%h ready=%b want 1/5/0000", k, vs4, ds4, r4);
      end
    end
    rs4 = 1'b1;
    #1;
    n_checks++;
    if (r4 !== 4'b0001) begin n_fail++; $display("FAIL bp_release_ready: got %b want 0001", r4); end
    @(posedge clk); #1 v4 = '0;
    @(negedge clk);
    n_checks++;
    if (vs4 !== 1'b1 || ds4 !== 32'h6 || id4 !== 2'd0) begin
      n_fail++;
      $display("FAIL bp_next: v=%b d=%h id=%0d want 1/6/0", vs4, ds4, id4);
    end
    @(negedge clk);
    n_checks++;
    if (vs4 !== 1'b0) begin n_fail++; $display("FAIL bp_drain: valid=%b want 0", vs4); end
  endtask

  task automatic test_wrap_n3();
    do_reset();
    v3[2] = 1'b1; d3[64 +: 32] = 32'h22; l3 = 3'b111; rs3 = 1'b1;
    @(posedge clk); #1;
    v3 = 3'b011; d3[31:0] = 32'h30; d3[63:32] = 32'h31;
    @(negedge clk);
    n_checks++;
    if (vs3 !== 1'b1 || ds3 !== 32'h22 || id3 !== 2'd2) begin
      n_fail++; $display("FAIL wrap_first: v=%b d=%h id=%0d want 1/22/2", vs3, ds3, id3);
    end
    n_checks++;
    if (r3 !== 3'b001) begin n_fail++; $display("FAIL wrap_ready: got %b want 001", r3); end
    @(posedge clk); #1 v3[0] = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ds3 !== 32'h30 || id3 !== 2'd0) begin n_fail++; $display("FAIL wrap_winner: d=%h id=%0d want 30/0", ds3, id3); end
    n_checks++;
    if (r3 !== 3'b010) begin n_fail++; $display("FAIL wrap_ready2: got %b want 010", r3); end
    @(posedge clk); #1 v3 = '0;
    @(negedge clk);
    n_checks++;
    if (ds3 !== 32'h31 || id3 !== 2'd1) begin n_fail++; $display("FAIL wrap_second: d=%h id=%0d want 31/1", ds3, id3); end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    v4[3] = 1'b1; d4[96 +: 32] = 32'hC0; l4 = 4'b0000; rs4 = 1'b1;
    @(posedge clk); #1;
    d4[96 +: 32] = 32'hC1;
    v4[0] = 1'b1; d4[31:0] = 32'h0D; l4[0] = 1'b1;
    @(negedge clk);
    n_checks++;
    if (r4 !== 4'b1000 || ds4 !== 32'hC0 || id4 !== 2'd3) begin
      n_fail++; $display("FAIL midrst_lock: ready=%b d=%h id=%0d want 1000/c0/3", r4, ds4, id4);
    end
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if (r4 !== 4'b0 || vs4 !== 1'b0) begin n_fail++; $display("FAIL midrst_clear: ready=%b v=%b want 0000/0", r4, vs4); end
    @(posedge clk); #2 rst = 1'b0;
    #1;
    n_checks++;
    if (r4 !== 4'b0001) begin n_fail++; $display("FAIL midrst_grant: got %b want 0001", r4); end
    @(posedge clk); #1 v4 = '0;
    @(negedge clk);
    n_checks++;
    if (vs4 !== 1'b1 || ds4 !== 32'h0D || ls4 !== 1'b1 || id4 !== 2'd0) begin
      n_fail++; $display("FAIL midrst_beat: v=%b d=%h l=%b id=%0d want 1/0d/1/0", vs4, ds4, ls4, id4);
    end
  endtask

  task automatic test_random();
    logic [31:0] bd [4][16];
    logic        bl [4][16];
    int          nb [4];
    int          pos [4];
    bit          m_lock;
    int          m_lock_id;
    int          m_ptr;
    logic [31:0] qd [$];
    logic        ql [$];
    int          qi [$];
    logic [3:0]  acc;
    logic [3:0]  exp_rdy;
    bit          slot_free;
    bit          done;
    int          w;
    int          j;
    for (int i = 0; i < 4; i++) begin
      nb[i]  = 8 + int'($urandom % 8);
      pos[i] = 0;
      for (int b = 0; b < 16; b++) begin
        bd[i][b] = {8'(i), 8'(b), 16'($urandom)};
        bl[i][b] = (($urandom % 3) == 0) || (b == nb[i] - 1);
      end
    end
    m_lock = 1'b0; m_lock_id = 0; m_ptr = 0; done = 1'b0;
    do_reset();
    acc = '0;
    for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
      for (int i = 0; i < 4; i++) begin
        if (acc[i]) v4[i] = 1'b0;
        if (pos[i] < nb[i] && !v4[i] && ($urandom % 2) == 1) begin
          v4[i] = 1'b1;
          d4[i*32 +: 32] = bd[i][pos[i]];
          l4[i] = bl[i][pos[i]];
        end
      end
      rs4 = ($urandom % 4) != 0;
      acc = '0;
      @(negedge clk);
      n_checks++;
      if (vs4 !== (qd.size() != 0)) begin
        n_fail++; $display("FAIL rnd_valid c%0d: got %b want %b", cyc, vs4, qd.size() != 0);
      end
      slot_free = (qd.size() == 0) || rs4;
      w = -1;
      if (m_lock) w = m_lock_id;
      else begin
        for (int k = 0; k < 4; k++) begin
          j = (m_ptr + k) % 4;
          if (w < 0 && v4[j]) w = j;
        end
      end
      exp_rdy = (w >= 0 && slot_free) ? 4'(1 << w) : 4'b0;
      n_checks++;
      if (r4 !== exp_rdy) begin n_fail++; $display("FAIL rnd_ready c%0d: got %b want %b", cyc, r4, exp_rdy); end
      if (qd.size() != 0 && rs4) begin
        n_checks++;
        if (ds4 !== qd[0] || ls4 !== ql[0] || id4 !== 2'(qi[0])) begin
          n_fail++;
          $display("FAIL rnd_beat c%0d: d=%h l=%b id=%0d want %h/%b/%0d", cyc, ds4, ls4, id4, qd[0], ql[0], qi[0]);
        end
        void'(qd.pop_front()); void'(ql.pop_front()); void'(qi.pop_front());
      end
      if (w >= 0 && slot_free && v4[w]) begin
        qd.push_back(bd[w][pos[w]]);
        ql.push_back(bl[w][pos[w]]);
        qi.push_back(w);
        if (bl[w][pos[w]]) begin
          m_lock = 1'b0;
          m_ptr  = (w + 1) % 4;
        end else if (!m_lock) begin
          m_lock    = 1'b1;
          m_lock_id = w;
        end
        pos[w]++;
        acc[w] = 1'b1;
      end
      done = (qd.size() == 0) && (pos[0] == nb[0]) && (pos[1] == nb[1]) &&
             (pos[2] == nb[2]) && (pos[3] == nb[3]);
      @(posedge clk); #1;
    end
    v4 = '0;
    n_checks++;
    if (!done) begin n_fail++; $display("FAIL rnd_timeout: done=%b want 1", done); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    v4 = '0; l4 = '0; d4 = '0; rs4 = 1'b0;
    v3 = '0; l3 = '0; d3 = '0; rs3 = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    test_reset();
    test_fairness();
    test_burst_lock();
    test_backpressure();
    test_wrap_n3();
    test_reset_mid_burst();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
